replay_store: RTL and testbench
===============================

Name: replay_store

Overview:
- Storage stage directly downstream of the replay-buffer FSM.
- Holds transmitted TLP words, tagged per packet with their 12-bit sequence number, in a circular RAM.
- On ACK, purges acknowledged packets. On NAK, purges acknowledged packets, then reports the remaining word count (num_to_rep) back to the FSM.
- Serves one word per FSM rep pulse until the replay ends.

Parameters:
DATA_W, 32, width of one stored TLP word
ADDR_W, 6, log2 of word RAM depth (64 words)
PKT_W, 3, log2 of packet-tag FIFO depth (8 outstanding packets)
SEQ_W, 12, sequence number width (fixed by the link protocol)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
we_i  in  1  write one word at the current write pointer
sof_i  in  1  with we_i: word is the first of a new packet; seq_i is sampled
wdata_i  in  DATA_W  word to store
seq_i  in  SEQ_W  sequence number of the packet that starts at sof_i
acknak_i  in  2  01 = ACK, 10 = NAK, 00/11 = none; 1-cycle pulse
ack_seq_i  in  SEQ_W  AckNak sequence number carried with acknak_i
rep_i  in  1  replay strobe from FSM: output the next word
ready_o  out  1  store accepts we_i this cycle
num_to_rep_o  out  SEQ_W  words to replay minus 1; valid while nak_done_o=1
nak_done_o  out  1  1-cycle pulse when num_to_rep_o is valid
rdata_o  out  DATA_W  replayed word
rvalid_o  out  1  rdata_o valid; asserted 1 cycle after rep_i
empty_o  out  1  no words stored
full_o  out  1  word RAM or tag FIFO full
ovf_o  out  1  sticky: write dropped; cleared only by reset

Behaviour:
- Reset values: all pointers and counts = 0, state IDLE, ready_o=1, empty_o=1, all other outputs 0.
- Word RAM: wr_ptr, rd_ptr (oldest unacked word), rep_ptr; ADDR_W+1-bit word count.
- Tag FIFO: each entry is {seq, start_addr}. Pushed on we_i&sof_i, popped by purge.
- Pointer wrap: all pointers wrap modulo 2^ADDR_W.
- Sequence compare: packet seq S is acked when (ack_seq_i - S) mod 4096 < 2048.
- Writes are accepted only when ready_o = !full_o && state in {IDLE, PURGE}.
- Any dropped write sets ovf_o. This includes we_i while not ready, and sof_i with the tag FIFO full.
- States:
  - IDLE: ACK -> PURGE; NAK -> NPURGE; ack_seq is latched on entry.
  - PURGE: each cycle, if the head tag is acked and the FIFO is non-empty, pop one tag and set rd_ptr to the next tag's start address, or to wr_ptr if none remains. Otherwise -> IDLE.
  - NPURGE: same pop rule. When no more pops apply -> NLOAD.
  - NLOAD: rep_ptr <= rd_ptr; num_to_rep_o <= word count - 1; pulse nak_done_o; -> REPLAY. If word count = 0: num_to_rep_o=0, nak_done_o pulses, next state IDLE, no replay.
  - REPLAY: each rep_i reads RAM[rep_ptr]; rdata_o/rvalid_o appear next cycle; rep_ptr increments. Exit to IDLE after the (num_to_rep_o+1)-th rep_i. rep_i received outside REPLAY is ignored.
- Simultaneous events:
  - we_i is written in the same cycle as an ACK is accepted.
  - A write and a purge pop in the same cycle leave the word count net-correct.
  - acknak_i arriving while not IDLE is dropped. The FSM does not issue it in that case.
- Word count limit: the count never exceeds 2^ADDR_W; full_o is asserted at count = 2^ADDR_W.
- Mid-operation reset returns everything to reset values immediately; stored data is discarded.

Decomposition:
- Shared package replay_pkg holds:
  - ACKNAK_NONE/ACK/NAK encodings
  - SEQ_W, the seq_acked() compare function
  - the state enum {IDLE, PURGE, NPURGE, NLOAD, REPLAY}
- One sub-module, replay_tag_fifo: synchronous FIFO of {seq, start_addr} with push/pop/head/full/empty.
- The word RAM is inferred inline.

Test Plan:
1. Reset, then write 4 packets of 10 words each (seq 0..3), then NAK with ack_seq=4095 -> no purge; nak_done_o pulses with num_to_rep_o=39; 40 rep_i pulses return the 40 words in order; state returns to IDLE.
2. Same fill, then ACK with ack_seq=1 -> 2 tags popped in 2 cycles; word count 20. Then NAK with ack_seq=1 -> num_to_rep_o=19; the first replayed word is the first word of seq 2.
3. Sequence wrap: packets seq 4094, 4095, 0, then ACK with ack_seq=0 -> all purged; empty_o=1.
4. Fill 64 words -> full_o=1, ready_o=0. A further we_i is dropped and ovf_o=1. An ACK frees space, after which ready_o=1.
5. NAK on an empty store -> nak_done_o with num_to_rep_o=0; rep_i is ignored; state is IDLE the next cycle.
6. Assert reset midway through a replay (after 5 rep_i) -> rvalid_o=0, empty_o=1 immediately; a subsequent write is stored at address 0.

Source files
------------

// File: rtl/replay_pkg.sv
// rtl/replay_pkg.sv - shared encodings, state enum and sequence compare for the replay store
package replay_pkg;

    localparam int SEQ_W = 12;

    localparam logic [1:0] ACKNAK_NONE = 2'b00;
    localparam logic [1:0] ACKNAK_ACK  = 2'b01;
    localparam logic [1:0] ACKNAK_NAK  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        PURGE,
        NPURGE,
        NLOAD,
        REPLAY
    } state_e;

    // A packet is covered by an AckNak when it lies in the half-window behind ack_seq.
    function automatic logic seq_acked(input logic [SEQ_W-1:0] ack_seq,
                                       input logic [SEQ_W-1:0] seq);
        logic [SEQ_W-1:0] diff;
        diff = ack_seq - seq;
        return !diff[SEQ_W-1];
    endfunction

endpackage

// File: rtl/replay_tag_fifo.sv
// rtl/replay_tag_fifo.sv - per-packet {seq, start_addr} FIFO with head and next-entry lookahead
module replay_tag_fifo
    import replay_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int PKT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [SEQ_W-1:0]  push_seq_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic              pop_i,
    output logic [SEQ_W-1:0]  head_seq_o,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              has_next_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int DEPTH = 1 << PKT_W;
    localparam logic [PKT_W:0] DEPTH_CNT = {1'b1, {PKT_W{1'b0}}};

    logic [SEQ_W-1:0]  seq_mem  [0:DEPTH-1];
    logic [ADDR_W-1:0] addr_mem [0:DEPTH-1];

    logic [PKT_W-1:0] wr_ptr_q, rd_ptr_q, rd_next;
    logic [PKT_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == DEPTH_CNT);
    assign empty_o    = (count_q == '0);
    assign has_next_o = (count_q[PKT_W:1] != '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign rd_next    = rd_ptr_q + 1'b1;

    assign head_seq_o  = seq_mem[rd_ptr_q];
    // The start of the entry behind the head becomes the new oldest-unacked address on a pop.
    assign next_addr_o = addr_mem[rd_next];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            seq_mem[wr_ptr_q]  <= push_seq_i;
            addr_mem[wr_ptr_q] <= push_addr_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_next;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/replay_store.sv
// rtl/replay_store.sv - circular TLP word store with ACK/NAK purge and word-by-word replay
module replay_store
    import replay_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int PKT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic              sof_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [SEQ_W-1:0]  seq_i,
    input  logic [1:0]        acknak_i,
    input  logic [SEQ_W-1:0]  ack_seq_i,
    input  logic              rep_i,
    output logic              ready_o,
    output logic [SEQ_W-1:0]  num_to_rep_o,
    output logic              nak_done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              ovf_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] ram [0:DEPTH-1];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d, rep_ptr_q;
    logic [ADDR_W:0]   count_q, count_d, rep_left_q;
    logic [SEQ_W-1:0]  ack_seq_q, num_q;
    logic [DATA_W-1:0] rdata_q;
    logic              nak_done_q, rvalid_q, ovf_q;

    logic              wr_en, push, pop, head_acked, rep_fire, acknak_valid;
    logic [SEQ_W-1:0]  head_seq, load_num;
    logic [ADDR_W-1:0] next_addr, gap;
    logic [ADDR_W:0]   popped, cnt_m1;
    logic              has_next, tag_full, tag_empty;

    replay_tag_fifo #(
        .ADDR_W (ADDR_W),
        .PKT_W  (PKT_W)
    ) u_tag_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_seq_i  (seq_i),
        .push_addr_i (wr_ptr_q),
        .pop_i       (pop),
        .head_seq_o  (head_seq),
        .next_addr_o (next_addr),
        .has_next_o  (has_next),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    assign full_o   = (count_q == DEPTH_CNT) || tag_full;
    assign empty_o  = (count_q == '0);
    assign ready_o  = !full_o && (state_q == IDLE || state_q == PURGE);
    assign wr_en    = we_i && ready_o;
    assign push     = wr_en && sof_i;
    assign rep_fire = (state_q == REPLAY) && rep_i;

    assign acknak_valid = (acknak_i == ACKNAK_ACK) || (acknak_i == ACKNAK_NAK);
    assign head_acked   = !tag_empty && seq_acked(ack_seq_q, head_seq);
    assign gap          = next_addr - rd_ptr_q;
    assign cnt_m1       = count_q - 1'b1;
    assign load_num     = (count_q == '0) ? '0 : {{(SEQ_W-ADDR_W-1){1'b0}}, cnt_m1};

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        popped   = '0;
        rd_ptr_d = rd_ptr_q;
        case (state_q)
            IDLE: begin
                case (acknak_i)
                    ACKNAK_ACK:  state_d = PURGE;
                    ACKNAK_NAK:  state_d = NPURGE;
                    ACKNAK_NONE: state_d = IDLE;
                    default:     state_d = IDLE;
                endcase
            end
            PURGE: begin
                if (head_acked) pop = 1'b1;
                else            state_d = IDLE;
            end
            NPURGE: begin
                if (head_acked) pop = 1'b1;
                else            state_d = NLOAD;
            end
            NLOAD:   state_d = (count_q == '0) ? IDLE : REPLAY;
            REPLAY: begin
                if (rep_fire && rep_left_q == ONE_CNT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Popping the last tag frees every stored word, which the modular gap cannot express when full.
        if (pop) begin
            if (has_next) begin
                rd_ptr_d = next_addr;
                popped   = {1'b0, gap};
            end else begin
                rd_ptr_d = wr_ptr_q;
                popped   = count_q;
            end
        end
        count_d = count_q + {{ADDR_W{1'b0}}, wr_en} - popped;
    end

    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rep_ptr_q  <= '0;
            count_q    <= '0;
            rep_left_q <= '0;
            ack_seq_q  <= '0;
            num_q      <= '0;
            rdata_q    <= '0;
            nak_done_q <= 1'b0;
            rvalid_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            if (wr_en)           wr_ptr_q <= wr_ptr_q + 1'b1;
            if (we_i && !ready_o) ovf_q   <= 1'b1;
            if (state_q == IDLE && acknak_valid) ack_seq_q <= ack_seq_i;
            nak_done_q <= (state_q == NLOAD);
            if (state_q == NLOAD) begin
                rep_ptr_q  <= rd_ptr_q;
                rep_left_q <= count_q;
                num_q      <= load_num;
            end else if (rep_fire) begin
                rep_ptr_q  <= rep_ptr_q + 1'b1;
                rep_left_q <= rep_left_q - 1'b1;
            end
            rvalid_q <= rep_fire;
            if (rep_fire) rdata_q <= ram[rep_ptr_q];
        end
    end

    assign num_to_rep_o = num_q;
    assign nak_done_o   = nak_done_q;
    assign rdata_o      = rdata_q;
    assign rvalid_o     = rvalid_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_replay_store.sv
// tb/tb_replay_store.sv - randomized self-checking bench for replay_store against a queue model
module tb_replay_store;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we_i = 1'b0, sof_i = 1'b0, rep_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [11:0] seq_i = '0, ack_seq_i = '0;
    logic [1:0]  acknak_i = '0;
    logic        ready_o, nak_done_o, rvalid_o, empty_o, full_o, ovf_o;
    logic [11:0] num_to_rep_o;
    logic [31:0] rdata_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mq[$];
    int          tseq[$];
    int          tlen[$];
    bit          movf;
    int          nseq;

    always #5 clk = ~clk;

    replay_store dut (
        .clk          (clk),
        .reset        (reset),
        .we_i         (we_i),
        .sof_i        (sof_i),
        .wdata_i      (wdata_i),
        .seq_i        (seq_i),
        .acknak_i     (acknak_i),
        .ack_seq_i    (ack_seq_i),
        .rep_i        (rep_i),
        .ready_o      (ready_o),
        .num_to_rep_o (num_to_rep_o),
        .nak_done_o   (nak_done_o),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .ovf_o        (ovf_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_acked(input int a, input int s);
        return ((a - s) & 4095) < 2048;
    endfunction

    function automatic bit m_full();
        return (mq.size() >= 64) || (tseq.size() >= 8);
    endfunction

    task automatic model_clear();
        mq.delete();
        tseq.delete();
        tlen.delete();
        movf = 1'b0;
    endtask

    task automatic model_purge(input int aseq);
        while (tseq.size() > 0 && m_acked(aseq, tseq[0])) begin
            repeat (tlen[0]) void'(mq.pop_front());
            void'(tseq.pop_front());
            void'(tlen.pop_front());
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_empty"}, 64'(empty_o), 64'(mq.size() == 0));
        check({tag, "_full"},  64'(full_o),  64'(m_full()));
        check({tag, "_ready"}, 64'(ready_o), 64'(!m_full()));
        check({tag, "_ovf"},   64'(ovf_o),   64'(movf));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        we_i = 1'b0; sof_i = 1'b0; rep_i = 1'b0; acknak_i = 2'b00;
        tick();
        tick();
        check("rst_ready",    64'(ready_o),      64'd1);
        check("rst_empty",    64'(empty_o),      64'd1);
        check("rst_full",     64'(full_o),       64'd0);
        check("rst_ovf",      64'(ovf_o),        64'd0);
        check("rst_nak_done", 64'(nak_done_o),   64'd0);
        check("rst_rvalid",   64'(rvalid_o),     64'd0);
        check("rst_num",      64'(num_to_rep_o), 64'd0);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic write_pkt(input int seq, input int len);
        logic [31:0] w;
        bit          acc;
        for (int i = 0; i < len; i++) begin
            w   = $urandom;
            acc = !m_full();
            we_i = 1'b1; sof_i = (i == 0); wdata_i = w; seq_i = 12'(seq);
            if (acc) begin
                mq.push_back(w);
                if (i == 0) begin
                    tseq.push_back(seq & 4095);
                    tlen.push_back(1);
                end else if (tlen.size() > 0) begin
                    tlen[tlen.size()-1]++;
                end
            end else begin
                movf = 1'b1;
            end
            tick();
            acknak_i = 2'b00;
        end
        we_i = 1'b0; sof_i = 1'b0;
    endtask

    task automatic do_ack(input int aseq);
        acknak_i = 2'b01; ack_seq_i = 12'(aseq);
        tick();
        acknak_i = 2'b00;
        repeat (11) tick();
        model_purge(aseq);
        check_status("ack");
    endtask

    task automatic do_nak(input int aseq, input int stop);
        bit got;
        int n;
        acknak_i = 2'b10; ack_seq_i = 12'(aseq);
        tick();
        acknak_i = 2'b00;
        model_purge(aseq);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (nak_done_o) got = 1'b1;
            else tick();
        end
        check("nak_done_seen", 64'(got), 64'd1);
        if (got) begin
            check("num_to_rep", 64'(num_to_rep_o), 64'((mq.size() == 0) ? 0 : mq.size() - 1));
            if (mq.size() == 0) begin
                check("nak_empty_idle", 64'(ready_o), 64'd1);
                rep_i = 1'b1;
                tick();
                rep_i = 1'b0;
                check("rep_ignored", 64'(rvalid_o), 64'd0);
            end else begin
                n = (stop >= 0 && stop < mq.size()) ? stop : mq.size();
                for (int i = 0; i < n; i++) begin
                    rep_i = 1'b1;
                    tick();
                    rep_i = 1'b0;
                    check("rep_valid", 64'(rvalid_o), 64'd1);
                    check("rep_data",  64'(rdata_o),  64'(mq[i]));
                end
                if (n == mq.size()) begin
                    check("replay_end_idle", 64'(ready_o), 64'(!m_full()));
                    tick();
                    check("replay_end_rvalid", 64'(rvalid_o), 64'd0);
                end
            end
        end
    endtask

    initial begin
        int op, len, aseq;
        do_reset();

        for (int s = 0; s < 4; s++) write_pkt(s, 10);
        do_nak(4095, -1);

        do_reset();
        for (int s = 0; s < 4; s++) write_pkt(s, 10);
        do_ack(1);
        do_nak(1, -1);

        do_reset();
        write_pkt(4094, 3);
        write_pkt(4095, 4);
        write_pkt(0, 2);
        do_ack(0);
        check("wrap_empty", 64'(empty_o), 64'd1);

        do_reset();
        for (int s = 10; s < 14; s++) write_pkt(s, 16);
        check_status("fill64");
        write_pkt(14, 1);
        check_status("drop");
        do_ack(10);
        check("ack_frees", 64'(ready_o), 64'd1);

        do_reset();
        do_nak(100, -1);

        do_reset();
        for (int s = 0; s < 3; s++) write_pkt(s, 6);
        do_nak(4095, 5);
        reset = 1'b1;
        #1;
        check("midrst_rvalid", 64'(rvalid_o), 64'd0);
        check("midrst_empty",  64'(empty_o),  64'd1);
        tick();
        reset = 1'b0;
        model_clear();
        write_pkt(7, 3);
        do_nak(6, -1);

        do_reset();
        nseq = $urandom_range(0, 4095);
        for (int it = 0; it < 60; it++) begin
            op   = $urandom_range(0, 9);
            len  = $urandom_range(1, 12);
            aseq = (nseq - 1 - $urandom_range(0, 6)) & 4095;
            if (op < 5) begin
                write_pkt(nseq, len);
                nseq = (nseq + 1) & 4095;
            end else if (op < 7) begin
                do_ack(aseq);
            end else if (op < 8 && mq.size() + len <= 64 && tseq.size() < 8) begin
                acknak_i = 2'b01; ack_seq_i = 12'(aseq);
                write_pkt(nseq, len);
                nseq = (nseq + 1) & 4095;
                repeat (12) tick();
                model_purge(aseq);
                check_status("ack_wr");
            end else begin
                do_nak(aseq, -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
